// File: rtl/range_frame_sequencer.sv
// Frame buffer between a sporadic valid/ready source and the range finder.
// Collects one frame of samples, then replays it as a gap-free burst.
module range_frame_sequencer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_go,
    output logic             out_finish,
    output logic             busy,
    output logic             trunc_err,
    input  logic             err_clear,
    output logic [7:0]       frame_cnt
);

    // state   | meaning
    // S_IDLE  | buffer empty, accepting
    // S_FILL  | at least one sample held, accepting
    // S_BURST | replaying frame; first cycle is the register-fill slot

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_BURST
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;

    logic accept;
    logic fills_buffer;
    logic close;
    logic last_rd;
    logic burst_done;

    assign in_ready     = (state != S_BURST);
    assign busy         = (state == S_BURST);
    assign accept       = in_valid & in_ready;
    assign fills_buffer = (count == CW'(DEPTH - 1));
    assign close        = accept & (in_last | fills_buffer);
    assign last_rd      = (({1'b0, rd_ptr} + CW'(1)) == count);
    // out_finish being high means the final sample is on the port this cycle
    assign burst_done   = (state == S_BURST) & out_finish;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (close) begin
                    state_nxt = S_BURST;
                end else if (accept) begin
                    state_nxt = S_FILL;
                end
            end
            S_FILL: begin
                if (close) begin
                    state_nxt = S_BURST;
                end
            end
            S_BURST: begin
                if (burst_done) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (accept) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            count  <= '0;
        end else if (burst_done) begin
            wr_ptr <= '0;
            count  <= '0;
        end else if (accept) begin
            wr_ptr <= wr_ptr + AW'(1);
            count  <= count + CW'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr     <= '0;
            out_data   <= '0;
            out_go     <= 1'b0;
            out_finish <= 1'b0;
        end else if (state == S_BURST && !out_finish) begin
            out_data   <= mem[rd_ptr];
            out_go     <= (rd_ptr == '0);
            out_finish <= last_rd;
            rd_ptr     <= rd_ptr + AW'(1);
        end else begin
            if (burst_done) begin
                rd_ptr <= '0;
            end
            out_data   <= '0;
            out_go     <= 1'b0;
            out_finish <= 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            frame_cnt <= '0;
        end else if (burst_done) begin
            frame_cnt <= frame_cnt + 8'd1;
        end
    end

    // An auto-close on the same edge as err_clear must still flag the error
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            trunc_err <= 1'b0;
        end else if (accept && fills_buffer && !in_last) begin
            trunc_err <= 1'b1;
        end else if (err_clear) begin
            trunc_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_range_frame_sequencer.sv
// Bench for range_frame_sequencer: frame-level reference model checked every
// cycle, plus literal expectations at key points of each directed scenario.
module tb_range_frame_sequencer;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;

    logic             clock = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_last;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_go;
    logic             out_finish;
    logic             busy;
    logic             trunc_err;
    logic             err_clear;
    logic [7:0]       frame_cnt;

    int checks = 0;
    int errors = 0;

    range_frame_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clock      (clock),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_go     (out_go),
        .out_finish (out_finish),
        .busy       (busy),
        .trunc_err  (trunc_err),
        .err_clear  (err_clear),
        .frame_cnt  (frame_cnt)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a frame is a list of samples; closing it schedules
    // one empty busy cycle followed by one output entry per sample.
    typedef struct packed {
        logic [7:0] d;
        logic       g;
        logic       f;
    } ent_t;

    ent_t       sched[$];
    logic [7:0] fq[$];
    ent_t       e_cur  = '0;
    logic       e_busy = 1'b0;
    logic [7:0] e_fc   = 8'd0;
    logic       e_te   = 1'b0;
    logic       m_ready;
    int         n;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            sched.delete();
            fq.delete();
            e_cur  = '0;
            e_busy = 1'b0;
            e_fc   = 8'd0;
            e_te   = 1'b0;
        end else begin
            m_ready = !e_busy;
            if (e_cur.f) e_fc = e_fc + 8'd1;
            if (sched.size() > 0) begin
                e_cur  = sched.pop_front();
                e_busy = 1'b1;
            end else begin
                e_cur  = '0;
                e_busy = 1'b0;
            end
            if (err_clear) e_te = 1'b0;
            if (in_valid && m_ready) begin
                fq.push_back(in_data);
                if (in_last || fq.size() == DEPTH) begin
                    if (!in_last) e_te = 1'b1;
                    n = fq.size();
                    for (int i = 0; i < n; i++)
                        sched.push_back(ent_t'{d: fq[i], g: (i == 0), f: (i == n - 1)});
                    fq.delete();
                    e_cur  = '0;
                    e_busy = 1'b1;
                end
            end
        end
    end

    always @(negedge clock) begin
        if (!reset) begin
            chk("m_out_data", 32'(out_data), 32'(e_cur.d));
            chk("m_out_go", 32'(out_go), 32'(e_cur.g));
            chk("m_out_finish", 32'(out_finish), 32'(e_cur.f));
            chk("m_busy", 32'(busy), 32'(e_busy));
            chk("m_in_ready", 32'(in_ready), 32'(!e_busy));
            chk("m_trunc_err", 32'(trunc_err), 32'(e_te));
            chk("m_frame_cnt", 32'(frame_cnt), 32'(e_fc));
        end
    end

    task automatic sync();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int c);
        repeat (c) sync();
    endtask

    task automatic send(input logic [7:0] d, input logic l);
        in_data  = d;
        in_valid = 1'b1;
        in_last  = l;
        sync();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
    endtask

    initial begin
        reset     = 1'b1;
        in_data   = '0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        err_clear = 1'b0;
        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        chk("rst_trunc_err", 32'(trunc_err), 32'd0);
        sync();
        reset = 1'b0;
        idle(2);

        // 1: three samples with gaps
        send(8'h11, 1'b0);
        idle(2);
        send(8'h22, 1'b0);
        idle(1);
        send(8'h33, 1'b1);
        @(negedge clock);
        chk("t1_slot_busy", 32'(busy), 32'd1);
        chk("t1_slot_go", 32'(out_go), 32'd0);
        @(negedge clock);
        chk("t1_s0", {out_go, out_finish, out_data}, {1'b1, 1'b0, 8'h11});
        @(negedge clock);
        chk("t1_s1", {out_go, out_finish, out_data}, {1'b0, 1'b0, 8'h22});
        @(negedge clock);
        chk("t1_s2", {out_go, out_finish, out_data}, {1'b0, 1'b1, 8'h33});
        @(negedge clock);
        chk("t1_after", {in_ready, busy, out_data}, {1'b1, 1'b0, 8'h00});
        chk("t1_frame_cnt", 32'(frame_cnt), 32'd1);
        sync();

        // 2: single-sample frame
        send(8'h5A, 1'b1);
        @(negedge clock);
        @(negedge clock);
        chk("t2_go_fin", {out_go, out_finish, out_data}, {1'b1, 1'b1, 8'h5A});
        idle(2);
        chk("t2_frame_cnt", 32'(frame_cnt), 32'd2);

        // 3: sixteen samples, auto-close
        for (int i = 0; i < DEPTH; i++) send(8'(i), 1'b0);
        @(negedge clock);
        chk("t3_trunc_set", 32'(trunc_err), 32'd1);
        @(negedge clock);
        chk("t3_first", {out_go, out_finish, out_data}, {1'b1, 1'b0, 8'h00});
        repeat (14) @(negedge clock);
        @(negedge clock);
        chk("t3_last", {out_go, out_finish, out_data}, {1'b0, 1'b1, 8'h0F});
        sync();
        err_clear = 1'b1;
        sync();
        err_clear = 1'b0;
        @(negedge clock);
        chk("t3_trunc_clr", 32'(trunc_err), 32'd0);
        sync();
        // set wins over a clear on the same edge
        for (int i = 0; i < DEPTH - 1; i++) send(8'(8'h80 + i), 1'b0);
        err_clear = 1'b1;
        send(8'h8F, 1'b0);
        err_clear = 1'b0;
        @(negedge clock);
        chk("t3_set_wins", 32'(trunc_err), 32'd1);
        idle(20);

        // 4: valid held during burst is ignored
        send(8'hC1, 1'b0);
        send(8'hC2, 1'b0);
        send(8'hC3, 1'b0);
        send(8'hC4, 1'b1);
        in_valid = 1'b1;
        in_data  = 8'h77;
        @(negedge clock);
        chk("t4_ready_low", 32'(in_ready), 32'd0);
        sync();
        sync();
        in_valid = 1'b0;
        in_data  = '0;
        idle(6);
        send(8'hA1, 1'b0);
        send(8'hA2, 1'b1);
        @(negedge clock);
        @(negedge clock);
        chk("t4_first", {out_go, out_data}, {1'b1, 8'hA1});
        @(negedge clock);
        chk("t4_second", {out_finish, out_data}, {1'b1, 8'hA2});
        idle(3);

        // 5: reset mid-burst
        for (int i = 0; i < 5; i++) send(8'(8'h51 + i), (i == 4));
        repeat (4) @(negedge clock);
        chk("t5_pre_s2", 32'(out_data), 32'h53);
        #2;
        reset = 1'b1;
        #1;
        chk("t5_rst_out", {out_go, out_finish, busy, out_data}, {3'b000, 8'h00});
        chk("t5_rst_cnt", 32'(frame_cnt), 32'd0);
        sync();
        sync();
        reset = 1'b0;
        @(negedge clock);
        chk("t5_ready", {in_ready, out_finish}, {1'b1, 1'b0});
        sync();

        // 6: frame counter wrap
        for (int j = 0; j < 255; j++) begin
            send(8'(j), 1'b1);
            idle(2);
        end
        chk("t6_cnt_255", 32'(frame_cnt), 32'd255);
        send(8'hEE, 1'b1);
        idle(2);
        chk("t6_cnt_wrap", 32'(frame_cnt), 32'd0);
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
